// File: rtl/mul_div_unit.sv
// Sequential signed multiply (radix-2 Booth) / divide (non-restoring) engine.
// Feeds the Z register pair: result_hi -> RZ_HI, result_lo -> RZ_LO.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FINISH = 2'd2} state_t;
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_next;
  logic [WIDTH:0]   acc_a;
  logic [WIDTH-1:0] acc_q;
  logic             q_m1;
  logic [WIDTH-1:0] m_reg;
  logic             op_q;
  logic             sign_a;
  logic             sign_q;
  logic [CW-1:0]    cnt;

  logic             div_zero;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_res;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign fsm_state = state;
  // Zero divisor is detected on the latched copy during the first CALC cycle.
  assign div_zero  = op_q && (m_reg == '0);

  always_comb begin
    m_ext     = {m_reg[WIDTH-1], m_reg};
    booth_sum = acc_a;
    case ({acc_q[0], q_m1})
      2'b01:   booth_sum = acc_a + m_ext;
      2'b10:   booth_sum = acc_a - m_ext;
      default: booth_sum = acc_a;
    endcase
    div_shift = {acc_a[WIDTH-1:0], acc_q[WIDTH-1]};
    div_res   = acc_a[WIDTH] ? div_shift + {1'b0, m_reg} : div_shift - {1'b0, m_reg};
    rem       = acc_a[WIDTH] ? acc_a[WIDTH-1:0] + m_reg : acc_a[WIDTH-1:0];
    a_mag     = operand_a[WIDTH-1] ? -operand_a : operand_a;
    b_mag     = operand_b[WIDTH-1] ? -operand_b : operand_b;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (div_zero || cnt == CW'(1)) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      result_hi   <= '0;
      result_lo   <= '0;
      acc_a       <= '0;
      acc_q       <= '0;
      q_m1        <= 1'b0;
      m_reg       <= '0;
      op_q        <= 1'b0;
      sign_a      <= 1'b0;
      sign_q      <= 1'b0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy        <= 1'b1;
          div_by_zero <= 1'b0;
          op_q        <= op;
          cnt         <= CW'(WIDTH);
          acc_a       <= '0;
          q_m1        <= 1'b0;
          if (op) begin
            m_reg  <= b_mag;
            acc_q  <= a_mag;
            sign_a <= operand_a[WIDTH-1];
            sign_q <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
          end else begin
            m_reg  <= operand_a;
            acc_q  <= operand_b;
            sign_a <= 1'b0;
            sign_q <= 1'b0;
          end
        end
        CALC: if (!div_zero) begin
          cnt <= cnt - CW'(1);
          if (op_q) begin
            acc_a <= div_res;
            acc_q <= {acc_q[WIDTH-2:0], ~div_res[WIDTH]};
          end else begin
            acc_a <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            acc_q <= {booth_sum[0], acc_q[WIDTH-1:1]};
            q_m1  <= acc_q[0];
          end
        end
        FINISH: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (div_zero) begin
            // acc_q still holds |dividend|; restore its sign.
            result_hi   <= sign_a ? -acc_q : acc_q;
            result_lo   <= '1;
            div_by_zero <= 1'b1;
          end else if (op_q) begin
            result_hi <= sign_a ? -rem : rem;
            result_lo <= sign_q ? -acc_q : acc_q;
          end else begin
            result_hi <= acc_a[WIDTH-1:0];
            result_lo <= acc_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit at WIDTH=32.
module tb_mul_div_unit;

  logic        clock;
  logic        clear;
  logic        start;
  logic        op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] result_hi;
  logic [31:0] result_lo;
  logic [1:0]  fsm_state;

  int total = 0;
  int bad   = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .result_hi(result_hi), .result_lo(result_lo), .fsm_state(fsm_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Called #1 after an edge; returns #1 after the start edge (E0).
  task automatic start_op(input logic o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clock); #1;
    start = 1'b0; operand_a = $urandom; operand_b = $urandom; op = $urandom_range(0, 1);
  endtask

  // Counts edges until done is seen (bounded); busy_drop counts early busy falls.
  task automatic wait_done(output int edges, output int busy_drop);
    edges = 0; busy_drop = 0;
    do begin
      @(posedge clock); #1;
      edges++;
      if (!done && !busy) busy_drop++;
    end while (!done && edges < 100);
  endtask

  task automatic test_reset;
    clear = 1'b0; start = 1'b0; op = 1'b0; operand_a = '0; operand_b = '0;
    repeat (2) @(posedge clock);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    total++; if ({result_hi, result_lo} !== 64'h0) begin bad++; $display("FAIL reset_result: got %h want 0", {result_hi, result_lo}); end
    clear = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic run_table(input logic o, input string name, input logic [31:0] va[4],
                           input logic [31:0] vb[4], input logic [31:0] vh[4],
                           input logic [31:0] vl[4], input int n);
    int edges, drop;
    for (int i = 0; i < n; i++) begin
      start_op(o, va[i], vb[i]);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy_start[%0d]: got %b want 1", name, i, busy); end
      wait_done(edges, drop);
      total++; if (edges !== 33) begin bad++; $display("FAIL %s_latency[%0d]: got %0d want 33", name, i, edges); end
      total++; if (drop !== 0) begin bad++; $display("FAIL %s_busy_early[%0d]: got %0d want 0", name, i, drop); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_end[%0d]: got %b want 0", name, i, busy); end
      total++; if (result_hi !== vh[i]) begin bad++; $display("FAIL %s_hi[%0d]: got %h want %h", name, i, result_hi, vh[i]); end
      total++; if (result_lo !== vl[i]) begin bad++; $display("FAIL %s_lo[%0d]: got %h want %h", name, i, result_lo, vl[i]); end
      total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL %s_dbz[%0d]: got %b want 0", name, i, div_by_zero); end
      @(posedge clock); #1;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL %s_done_pulse[%0d]: got %b want 0", name, i, done); end
    end
  endtask

  task automatic test_mul;
    logic [31:0] va[4] = '{32'h7, 32'h80000000, 32'h7FFFFFFF, 32'h0};
    logic [31:0] vb[4] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'h0};
    logic [31:0] vh[4] = '{32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFF, 32'h0};
    logic [31:0] vl[4] = '{32'hFFFFFFEB, 32'h00000000, 32'h80000001, 32'h0};
    run_table(1'b0, "mul", va, vb, vh, vl, 3);
  endtask

  task automatic test_div;
    logic [31:0] va[4] = '{32'hFFFFFFF9, 32'h7, 32'h80000000, 32'd100};
    logic [31:0] vb[4] = '{32'h2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd7};
    logic [31:0] vh[4] = '{32'hFFFFFFFF, 32'h1, 32'h0, 32'd2};
    logic [31:0] vl[4] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'd14};
    run_table(1'b1, "div", va, vb, vh, vl, 4);
  endtask

  task automatic test_div_zero;
    int edges, drop;
    start_op(1'b1, 32'd25, 32'd0);
    wait_done(edges, drop);
    total++; if (edges !== 2) begin bad++; $display("FAIL dbz_latency: got %0d want 2", edges); end
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag: got %b want 1", div_by_zero); end
    total++; if (result_hi !== 32'h19) begin bad++; $display("FAIL dbz_hi: got %h want 00000019", result_hi); end
    total++; if (result_lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL dbz_lo: got %h want ffffffff", result_lo); end
    @(posedge clock); #1;
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_held: got %b want 1", div_by_zero); end
    start_op(1'b0, 32'd2, 32'd3);
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL dbz_cleared: got %b want 0", div_by_zero); end
    wait_done(edges, drop);
    total++; if (edges !== 33) begin bad++; $display("FAIL dbz_next_latency: got %0d want 33", edges); end
    total++; if ({result_hi, result_lo} !== 64'd6) begin bad++; $display("FAIL dbz_next_mul: got %h want 6", {result_hi, result_lo}); end
    @(posedge clock); #1;
  endtask

  task automatic test_ignore_start;
    int edges, drop, extra;
    start_op(1'b0, 32'd5, 32'd6);
    repeat (4) @(posedge clock);
    #1;
    start = 1'b1; op = 1'b1; operand_a = 32'd99; operand_b = 32'd0;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(edges, drop);
    total++; if (edges !== 28) begin bad++; $display("FAIL ignore_latency: got %0d want 28", edges); end
    total++; if ({result_hi, result_lo} !== 64'd30) begin bad++; $display("FAIL ignore_result: got %h want 30", {result_hi, result_lo}); end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (done) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL ignore_extra_done: got %0d want 0", extra); end
  endtask

  task automatic test_back_to_back;
    int edges, drop;
    start_op(1'b0, 32'h7, 32'hFFFFFFFD);
    wait_done(edges, drop);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_first_done: got %b want 1", done); end
    start_op(1'b1, 32'hFFFFFFF9, 32'h2);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accepted: got %b want 1", busy); end
    repeat (20) @(posedge clock);
    #1;
    total++; if ({result_hi, result_lo} !== 64'hFFFFFFFF_FFFFFFEB) begin bad++; $display("FAIL b2b_hold: got %h want ffffffffffffffeb", {result_hi, result_lo}); end
    wait_done(edges, drop);
    total++; if (edges !== 13) begin bad++; $display("FAIL b2b_latency: got %0d want 13", edges); end
    total++; if ({result_hi, result_lo} !== 64'hFFFFFFFF_FFFFFFFD) begin bad++; $display("FAIL b2b_second: got %h want fffffffffffffffd", {result_hi, result_lo}); end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid;
    int edges, drop, seen;
    start_op(1'b1, 32'd100, 32'd7);
    repeat (9) @(posedge clock);
    @(posedge clock); #2;
    clear = 1'b0;
    #1;
    total++; if ({busy, done, div_by_zero} !== 3'b000) begin bad++; $display("FAIL midreset_flags: got %b want 000", {busy, done, div_by_zero}); end
    total++; if ({result_hi, result_lo} !== 64'h0) begin bad++; $display("FAIL midreset_result: got %h want 0", {result_hi, result_lo}); end
    total++; if (fsm_state !== 2'd0) begin bad++; $display("FAIL midreset_state: got %0d want 0", fsm_state); end
    repeat (3) @(posedge clock);
    #1;
    clear = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (done || busy) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midreset_no_done: got %0d want 0", seen); end
    start_op(1'b1, 32'd100, 32'd7);
    wait_done(edges, drop);
    total++; if (edges !== 33) begin bad++; $display("FAIL midreset_latency: got %0d want 33", edges); end
    total++; if (result_lo !== 32'd14) begin bad++; $display("FAIL midreset_quot: got %0d want 14", result_lo); end
    total++; if (result_hi !== 32'd2) begin bad++; $display("FAIL midreset_rem: got %0d want 2", result_hi); end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_div;
    test_div_zero;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
